// File: rtl/gate_bank_pipe.sv
// Bank of per-channel reduction gates with wand/wor resolution, contention flag
// and a DEPTH-stage elastic valid/ready pipeline with a saturating conflict counter.
module gate_bank_pipe #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 2,
   parameter int CNT_W    = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS*2-1:0]     in_mode,
   input  logic                      res_mode,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CHANNELS-1:0]       out_bits,
   output logic                      out_resolved,
   output logic                      out_conflict,
   input  logic                      clr_count,
   output logic [CNT_W-1:0]          conflict_count
);

   typedef enum logic [1:0] {
      MODE_AND = 2'b00,
      MODE_OR  = 2'b01,
      MODE_XOR = 2'b10,
      MODE_NOR = 2'b11
   } gate_mode_e;

   logic [CHANNELS-1:0]             s1_bits;
   logic                            s1_res;
   logic                            s1_conf;
   logic [WIDTH-1:0]                word;

   logic [DEPTH:1]                  v;
   logic [DEPTH:1]                  en;
   logic [DEPTH:1]                  res_q;
   logic [DEPTH:1]                  conf_q;
   logic [DEPTH:1][CHANNELS-1:0]    bits_q;
   logic [CNT_W-1:0]                cnt;
   logic                            acc;

   always_comb begin
      s1_bits = '0;
      word    = '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         word = in_data[c*WIDTH +: WIDTH];
         unique case (gate_mode_e'(in_mode[c*2 +: 2]))
            MODE_AND: s1_bits[c] = &word;
            MODE_OR:  s1_bits[c] = |word;
            MODE_XOR: s1_bits[c] = ^word;
            MODE_NOR: s1_bits[c] = ~|word;
         endcase
      end
      s1_res  = res_mode ? |s1_bits : &s1_bits;
      s1_conf = (|s1_bits) & ~(&s1_bits);
   end

   // A stage may load when it is empty or its word leaves this cycle; the
   // chain is folded back from the output so a stall ripples up in one cycle.
   always_comb begin
      en         = '0;
      acc        = ~v[DEPTH] | out_ready;
      en[DEPTH]  = acc;
      for (int unsigned k = int'(DEPTH) - 1; k >= 1; k--) begin
         acc   = ~v[k] | acc;
         en[k] = acc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v      <= '0;
         res_q  <= '0;
         conf_q <= '0;
         bits_q <= '0;
      end else begin
         if (en[1]) begin
            v[1]      <= in_valid;
            bits_q[1] <= s1_bits;
            res_q[1]  <= s1_res;
            conf_q[1] <= s1_conf;
         end
         for (int unsigned k = 2; k <= DEPTH; k++) begin
            if (en[k]) begin
               v[k]      <= v[k-1];
               bits_q[k] <= bits_q[k-1];
               res_q[k]  <= res_q[k-1];
               conf_q[k] <= conf_q[k-1];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr_count) begin
         cnt <= '0;
      end else if (v[DEPTH] & out_ready & conf_q[DEPTH] & ~(&cnt)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign in_ready       = en[1];
   assign out_valid      = v[DEPTH];
   assign out_bits       = bits_q[DEPTH];
   assign out_resolved   = res_q[DEPTH];
   assign out_conflict   = conf_q[DEPTH];
   assign conflict_count = cnt;

endmodule

// File: tb/tb_gate_bank_pipe.sv
// Scoreboard bench for gate_bank_pipe: directed vectors with hand-computed results,
// plus a 1-channel/1-bit/1-stage instance for the degenerate configuration.
module tb_gate_bank_pipe;
   localparam int C  = 4;
   localparam int W  = 8;
   localparam int D  = 2;
   localparam int CW = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [C*W-1:0]   in_data = '0;
   logic [C*2-1:0]   in_mode = '0;
   logic             res_mode = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [C-1:0]     out_bits;
   logic             out_resolved;
   logic             out_conflict;
   logic             clr_count = 1'b0;
   logic [CW-1:0]    conflict_count;

   logic             s_in_valid = 1'b0;
   logic             s_in_ready;
   logic [0:0]       s_in_data = '0;
   logic [1:0]       s_in_mode = '0;
   logic             s_res_mode = 1'b0;
   logic             s_out_valid;
   logic             s_out_ready = 1'b1;
   logic [0:0]       s_out_bits;
   logic             s_out_resolved;
   logic             s_out_conflict;
   logic             s_clr = 1'b0;
   logic [3:0]       s_count;

   gate_bank_pipe #(.CHANNELS(C), .WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_mode(in_mode), .res_mode(res_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
      .out_resolved(out_resolved), .out_conflict(out_conflict),
      .clr_count(clr_count), .conflict_count(conflict_count)
   );

   gate_bank_pipe #(.CHANNELS(1), .WIDTH(1), .DEPTH(1), .CNT_W(4)) dut1 (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_data(s_in_data), .in_mode(s_in_mode), .res_mode(s_res_mode),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_bits(s_out_bits),
      .out_resolved(s_out_resolved), .out_conflict(s_out_conflict),
      .clr_count(s_clr), .conflict_count(s_count)
   );

   typedef struct {
      logic [C-1:0] bits;
      logic         res;
      logic         conf;
   } exp_t;

   typedef struct {
      logic [31:0]  d;
      logic [7:0]   m;
      logic         rm;
      logic [3:0]   eb;
      logic         er;
      logic         ec;
   } vec_t;

   // Modes are packed {ch3,ch2,ch1,ch0}; 00 and, 01 or, 10 xor, 11 nor.
   vec_t tbl [10] = '{
      '{32'h00000000, 8'hFF, 1'b0, 4'hF, 1'b1, 1'b0},
      '{32'h00000000, 8'h00, 1'b1, 4'h0, 1'b0, 1'b0},
      '{32'h01020304, 8'hAA, 1'b0, 4'hD, 1'b0, 1'b1},
      '{32'h80000000, 8'h55, 1'b1, 4'h8, 1'b1, 1'b1},
      '{32'hFFFFFF7F, 8'h00, 1'b0, 4'hE, 1'b0, 1'b1},
      '{32'h000000FF, 8'hFF, 1'b1, 4'hE, 1'b1, 1'b1},
      '{32'h12345678, 8'hAA, 1'b1, 4'h4, 1'b1, 1'b1},
      '{32'hFF00FF00, 8'hB1, 1'b0, 4'h6, 1'b0, 1'b1},
      '{32'hAAAAAAAA, 8'h55, 1'b0, 4'hF, 1'b1, 1'b0},
      '{32'h00000001, 8'hAA, 1'b0, 4'h1, 1'b0, 1'b1}
   };

   vec_t t1v = '{32'h810F00FF, 8'hE4, 1'b1, 4'h1, 1'b1, 1'b1};
   vec_t t4v = '{32'hFFFFFFFF, 8'h00, 1'b0, 4'hF, 1'b1, 1'b0};

   // Index = mode*2 + bit: and/or/xor pass the bit, nor inverts it.
   logic [7:0] w1exp = 8'h6A;

   exp_t sb [$];
   int   pop_cyc [$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: actual timeout, required completion");
      $fatal(1, "bench did not complete");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   task automatic push_vec(input vec_t v, output int tries);
      logic hs;
      bit   ok;
      ok    = 1'b0;
      tries = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = v.d;
         in_mode  = v.m;
         res_mode = v.rm;
         tries++;
         #1 hs = in_ready;
         @(posedge clk);
         if (hs) begin
            sb.push_back('{bits: v.eb, res: v.er, conf: v.ec});
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL push_timeout: actual in_ready stuck low, required accept");
      end
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: actual %0d pending, required 0", sb.size());
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin : monitor
      logic          held;
      logic [C-1:0]  hb;
      logic          hr;
      logic          hc;
      logic          hs_conf;
      exp_t          e;
      logic [CW-1:0] exp_cnt;
      held    = 1'b0;
      hb      = '0;
      hr      = 1'b0;
      hc      = 1'b0;
      exp_cnt = '0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_out_bits", out_bits, 0);
            check("rst_resolved", out_resolved, 0);
            check("rst_conflict", out_conflict, 0);
            check("rst_count", conflict_count, 0);
            sb.delete();
            exp_cnt = '0;
            held    = 1'b0;
         end else begin
            check("count", conflict_count, exp_cnt);
            if (held) begin
               check("hold_valid", out_valid, 1);
               check("hold_bits", out_bits, hb);
               check("hold_resolved", out_resolved, hr);
               check("hold_conflict", out_conflict, hc);
            end
            held = out_valid && !out_ready;
            hb   = out_bits;
            hr   = out_resolved;
            hc   = out_conflict;
            hs_conf = 1'b0;
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_output: actual bits %0h, required no output", out_bits);
               end else begin
                  e = sb.pop_front();
                  check("out_bits", out_bits, e.bits);
                  check("out_resolved", out_resolved, e.res);
                  check("out_conflict", out_conflict, e.conf);
                  pop_cyc.push_back(cyc);
                  hs_conf = e.conf;
               end
            end
            if (clr_count) exp_cnt = '0;
            else if (hs_conf && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
         end
      end
   end

   initial begin : stim
      int  tries;
      bit  found;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // T1: single word, latency and result
      push_vec(t1v, tries);
      @(negedge clk);
      in_valid = 1'b0;
      #1 check("t1_lat_cycle1", out_valid, 0);
      @(negedge clk);
      #1 check("t1_lat_cycle2", out_valid, 1);
      check("t1_bits", out_bits, 4'b0001);
      drain();
      check("t1_count", conflict_count, 1);

      // T2: back-to-back stream
      pop_cyc.delete();
      for (int i = 0; i < 10; i++) begin
         push_vec(tbl[i], tries);
         check("t2_in_ready", tries, 1);
      end
      idle();
      drain();
      check("t2_num_out", pop_cyc.size(), 10);
      if (pop_cyc.size() == 10) check("t2_consecutive", pop_cyc[9] - pop_cyc[0], 9);
      check("t2_count", conflict_count, 8);

      // T3: output stall, fill, then simultaneous pop and push
      @(negedge clk);
      out_ready = 1'b0;
      push_vec(t1v, tries);
      push_vec(tbl[2], tries);
      check("t3_second_accept", tries, 1);
      @(negedge clk);
      in_data  = tbl[3].d;
      in_mode  = tbl[3].m;
      res_mode = tbl[3].rm;
      repeat (3) begin
         #1 check("t3_stall_in_ready", in_ready, 0);
         check("t3_stall_valid", out_valid, 1);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1 check("t3_release_in_ready", in_ready, 1);
      @(posedge clk);
      sb.push_back('{bits: tbl[3].eb, res: tbl[3].er, conf: tbl[3].ec});
      idle();
      drain();
      check("t3_count", conflict_count, 11);

      // T4: all and on FF, wand: no conflict, count unchanged
      push_vec(t4v, tries);
      idle();
      drain();
      check("t4_count", conflict_count, 11);

      // T5: saturation, then clear racing an increment
      for (int i = 0; i < 260; i++) push_vec(t1v, tries);
      idle();
      drain();
      check("t5_saturated", conflict_count, 8'hFF);
      push_vec(t1v, tries);
      @(negedge clk);
      in_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (out_valid) begin
            clr_count = 1'b1;
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!found) begin
         tests++;
         fails++;
         $display("FAIL t5_wait_valid: actual no output, required output");
      end
      @(negedge clk);
      clr_count = 1'b0;
      #1 check("t5_clear_wins", conflict_count, 0);
      drain();

      // T6: reset with two words in flight
      push_vec(t1v, tries);
      idle();
      drain();
      check("t6_pre_count", conflict_count, 1);
      out_ready = 1'b0;
      push_vec(t1v, tries);
      push_vec(tbl[3], tries);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      #1 check("t6_rst_valid", out_valid, 0);
      check("t6_rst_count", conflict_count, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (6) begin
         @(negedge clk);
         #1 check("t6_quiet", out_valid, 0);
      end
      check("t6_sb_empty", sb.size(), 0);

      // Degenerate instance: CHANNELS=1, WIDTH=1, DEPTH=1
      for (int m = 0; m < 4; m++) begin
         for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            s_in_valid = 1'b1;
            s_in_data  = b[0:0];
            s_in_mode  = m[1:0];
            s_res_mode = m[0];
            #1 check("c1_in_ready", s_in_ready, 1);
            @(negedge clk);
            s_in_valid = 1'b0;
            #1 check("c1_valid", s_out_valid, 1);
            check("c1_bit", s_out_bits, w1exp[m*2+b]);
            check("c1_resolved", s_out_resolved, w1exp[m*2+b]);
            check("c1_conflict", s_out_conflict, 0);
         end
      end
      @(negedge clk);
      #1 check("c1_count", s_count, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
